// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end that turns word read/write requests into
// atomic two-beat command sequences for the command-coded RAM. Optional macro: RAM_ARBITER_ADDR_CACHE_EN.
module ram_arbiter #(
    parameter int ADDR_SIZE     = 8,
    parameter bit RR_RESET_LAST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [2*ADDR_SIZE-1:0] addr,
    input  logic [2*ADDR_SIZE-1:0] wdata,
    output logic [1:0]             ack,
    output logic [ADDR_SIZE-1:0]   rdata,
    output logic                   rd_err,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RD_DONE} state_t;
    state_t state, state_nx;
    logic id_q, last, gnt, hit;
    logic [ADDR_SIZE-1:0] addr_q, wdata_q, addr_sel, wdata_sel;

    // On a tie the requester that was not served last wins
    assign gnt       = (req == 2'b11) ? ~last : req[1];
    assign addr_sel  = gnt ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
    assign wdata_sel = gnt ? wdata[2*ADDR_SIZE-1:ADDR_SIZE] : wdata[ADDR_SIZE-1:0];

`ifdef RAM_ARBITER_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] wr_sh, rd_sh;
    logic wr_v, rd_v;
    // Shadows of the RAM's own address registers, valid once an address beat has issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sh <= '0;
            rd_sh <= '0;
            wr_v  <= 1'b0;
            rd_v  <= 1'b0;
        end else begin
            if (state == WR_ADDR) begin
                wr_sh <= addr_q;
                wr_v  <= 1'b1;
            end
            if (state == RD_ADDR) begin
                rd_sh <= addr_q;
                rd_v  <= 1'b1;
            end
        end
    end
    assign hit = we[gnt] ? (wr_v && addr_sel == wr_sh) : (rd_v && addr_sel == rd_sh);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        ack          = '0;
        case (state)
            IDLE:    if (|req) state_nx = we[gnt] ? (hit ? WR_DATA : WR_ADDR) : (hit ? RD_CMD : RD_ADDR);
            WR_ADDR: begin
                ram_din      = {2'b00, addr_q};
                ram_rx_valid = 1'b1;
                state_nx     = WR_DATA;
            end
            WR_DATA: begin
                ram_din      = {2'b01, wdata_q};
                ram_rx_valid = 1'b1;
                ack[id_q]    = 1'b1;
                state_nx     = IDLE;
            end
            RD_ADDR: begin
                ram_din      = {2'b10, addr_q};
                ram_rx_valid = 1'b1;
                state_nx     = RD_CMD;
            end
            RD_CMD: begin
                ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
                ram_rx_valid = 1'b1;
                state_nx     = RD_WAIT;
            end
            RD_WAIT: state_nx = RD_DONE;
            RD_DONE: begin
                ack[id_q] = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            last    <= RR_RESET_LAST;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            rd_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req) begin
                id_q    <= gnt;
                last    <= gnt;
                addr_q  <= addr_sel;
                wdata_q <= wdata_sel;
            end
            // The RAM only refreshes dout/tx_valid on a read command, so tx_valid is a level, never an event
            if (state == RD_WAIT) begin
                rdata <= ram_dout;
                if (!ram_tx_valid) rd_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural command-coded RAM.
// Honours RAM_ARBITER_ADDR_CACHE_EN when predicting which address beats are skipped.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, we = '0, ack;
    logic [15:0] addr = '0, wdata = '0;
    logic [7:0]  rdata, ram_dout;
    logic        rd_err, ram_rx_valid, ram_tx_valid;
    logic [9:0]  ram_din;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rd_err(rd_err), .ram_din(ram_din),
        .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: 00 addr / 01 data writes, 10 addr / 11 reads
    logic [7:0] mem [256];
    logic [7:0] wa, ra;
    logic       force_low = 1'b0;
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: wa <= ram_din[7:0];
                2'b01: mem[wa] <= ram_din[7:0];
                2'b10: ra <= ram_din[7:0];
                default: begin
                    ram_dout     <= mem[ra];
                    ram_tx_valid <= !force_low;
                end
            endcase
        end
    end

    typedef struct { logic [9:0] din; int c; } beat_t;
    typedef struct { logic [1:0] ack; logic [7:0] rdata; logic err; int c; } ack_t;
    beat_t beat_q[$];
    ack_t  ack_q[$];
    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    beat_t b;
    ack_t  a;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_state", 32'({ack, ram_rx_valid, ram_din, rdata, rd_err}), 32'd0);
        end else begin
            if (ram_rx_valid) begin
                if (beat_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL beat_extra @cyc %0d: got %0h expected no beat", cyc, ram_din);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_din", 32'(ram_din), 32'(b.din));
                    chk("beat_cyc", 32'(cyc), 32'(b.c));
                end
            end
            while (beat_q.size() != 0 && beat_q[0].c <= cyc) begin
                n_chk++; n_err++;
                $display("FAIL beat_missing @cyc %0d: got none expected %0h", cyc, beat_q[0].din);
                void'(beat_q.pop_front());
            end
            if (ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL ack_extra @cyc %0d: got %0b expected none", cyc, ack);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_vec", 32'(ack), 32'(a.ack));
                    chk("ack_cyc", 32'(cyc), 32'(a.c));
                    chk("rdata", 32'(rdata), 32'(a.rdata));
                    chk("rd_err", 32'(rd_err), 32'(a.err));
                end
            end
            while (ack_q.size() != 0 && ack_q[0].c <= cyc) begin
                n_chk++; n_err++;
                $display("FAIL ack_missing @cyc %0d: got none expected %0b", cyc, ack_q[0].ack);
                void'(ack_q.pop_front());
            end
        end
    end

    // Reference state maintained only by the stimulus side
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd = '0, wsh = '0, rsh = '0;
    logic       err_exp = 1'b0, wv = 1'b0, rv = 1'b0;

    task automatic push_beat(input logic [9:0] din, input int c);
        beat_t e;
        e.din = din; e.c = c;
        beat_q.push_back(e);
    endtask

    task automatic push_ack(input int id, input logic [7:0] rd, input logic err, input int c);
        ack_t e;
        e.ack = id != 0 ? 2'b10 : 2'b01; e.rdata = rd; e.err = err; e.c = c;
        ack_q.push_back(e);
    endtask

    task automatic do_reset();
        req = '0; rst_n = 1'b0;
        last_rd = '0; err_exp = 1'b0; wv = 1'b0; rv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called #1 after a rising edge with the arbiter idle; returns #1 after the edge ending the ack cycle
    task automatic run(input int id, input bit w, input logic [7:0] ad, input logic [7:0] d);
        bit hit = 1'b0;
        int k = cyc;
`ifdef RAM_ARBITER_ADDR_CACHE_EN
        hit = w ? (wv && ad == wsh) : (rv && ad == rsh);
        if (!hit && w) begin wsh = ad; wv = 1'b1; end
        if (!hit && !w) begin rsh = ad; rv = 1'b1; end
`endif
        req[id] = 1'b1; we[id] = w; addr[id*8 +: 8] = ad; wdata[id*8 +: 8] = d;
        if (w) begin
            if (!hit) push_beat({2'b00, ad}, k + 1);
            push_beat({2'b01, d}, k + (hit ? 1 : 2));
            ref_mem[ad] = d;
            push_ack(id, last_rd, err_exp, k + (hit ? 1 : 2));
        end else begin
            if (!hit) push_beat({2'b10, ad}, k + 1);
            push_beat(10'h300, k + (hit ? 1 : 2));
            last_rd = ref_mem[ad];
            if (force_low) err_exp = 1'b1;
            push_ack(id, last_rd, err_exp, k + (hit ? 3 : 4));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[id]) break;
        end
        @(posedge clk);
        #1 req[id] = 1'b0;
    endtask

    initial begin
        int k;
        do_reset();
        run(0, 1'b1, 8'h12, 8'hA5);
        run(1, 1'b0, 8'h12, 8'h00);
        run(0, 1'b1, 8'h01, 8'h3C);
        run(1, 1'b1, 8'h02, 8'hC3);

        // Both requesters reading continuously from reset: grants 0,1,0,1
        do_reset();
        k = cyc; we = 2'b00; addr = {8'h02, 8'h01}; req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            push_beat({2'b10, (g % 2 != 0) ? 8'h02 : 8'h01}, k + 5 * g + 1);
            push_beat(10'h300, k + 5 * g + 2);
            last_rd = (g % 2 != 0) ? ref_mem[8'h02] : ref_mem[8'h01];
            push_ack(g % 2, last_rd, 1'b0, k + 5 * g + 4);
        end
`ifdef RAM_ARBITER_ADDR_CACHE_EN
        rsh = 8'h02; rv = 1'b1;
`endif
        repeat (20) @(posedge clk);
        #1 req = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Reset landing in RD_CMD abandons the read; the reissue completes normally
        do_reset();
        k = cyc; we[0] = 1'b0; addr[7:0] = 8'h12; req[0] = 1'b1;
        push_beat(10'h212, k + 1);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run(0, 1'b0, 8'h12, 8'h00);

        // Missing tx_valid sets a sticky error
        force_low = 1'b1;
        run(1, 1'b0, 8'h12, 8'h00);
        force_low = 1'b0;
        run(0, 1'b0, 8'h01, 8'h00);
        run(1, 1'b1, 8'h30, 8'h77);

        // Repeated address: cached builds skip the address beat
        do_reset();
        run(0, 1'b1, 8'h40, 8'h11);
        run(0, 1'b1, 8'h40, 8'h22);
        run(1, 1'b0, 8'h40, 8'h00);
        run(1, 1'b0, 8'h40, 8'h00);

        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port command-coded RAM (10-bit din = {cmd[1:0], payload[7:0]}).
- Converts simple word-level read/write requests into the RAM's two-beat command sequences:
  - write: 00 addr, then 01 data
  - read: 10 addr, then 11
- Keeps each sequence atomic so beats from different requesters never interleave.
- Sits between the host-side requesters (SPI slave path, test/BIST port) and RAM.

Parameters:
- ADDR_SIZE, 8, address/data width; RAM din width is ADDR_SIZE+2.
- RR_RESET_LAST, 1, value of the last-served pointer after reset (1 means requester 0 wins the first tie).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request per requester; held until that requester's ack.
- we  in  2  per requester: 1 = write, 0 = read; stable while req is high.
- addr  in  2*ADDR_SIZE  per-requester address; requester i uses slice [i*ADDR_SIZE +: ADDR_SIZE].
- wdata  in  2*ADDR_SIZE  per-requester write data, same slicing.
- ack  out  2  one-cycle completion pulse per requester.
- rdata  out  ADDR_SIZE  last read data; valid while the read ack is high, held afterwards.
- rd_err  out  1  sticky flag: ram_tx_valid was low when read data was expected.
- ram_din  out  ADDR_SIZE+2  RAM command/payload.
- ram_rx_valid  out  1  RAM beat strobe.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read-valid.

Behaviour:
- Reset (async, any state):
  - state = IDLE; ack = 0; ram_rx_valid = 0; ram_din = 0; rdata = 0; rd_err = 0; last-served = RR_RESET_LAST.
  - Any in-flight sequence is abandoned; requesters must reissue.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RD_DONE.
- ram_din, ram_rx_valid and ack are Moore outputs decoded from state plus latched fields (no combinational path from req).
- IDLE arbitration:
  - ram_rx_valid = 0.
  - If exactly one req bit is high, grant it.
  - If both are high, grant the requester that is not last-served.
  - On grant: latch the id, we, addr and wdata; update last-served.
  - Next state: WR_ADDR if we = 1, else RD_ADDR.
  - No req: stay in IDLE.
- WR_ADDR: ram_din = {2'b00, addr_q}; ram_rx_valid = 1 → WR_DATA.
- WR_DATA: ram_din = {2'b01, wdata_q}; ram_rx_valid = 1; ack[id] = 1 → IDLE.
- RD_ADDR: ram_din = {2'b10, addr_q}; ram_rx_valid = 1 → RD_CMD.
- RD_CMD: ram_din = {2'b11, 0}; ram_rx_valid = 1 → RD_WAIT.
- RD_WAIT:
  - ram_rx_valid = 0; the RAM has updated dout/tx_valid this cycle.
  - Register rdata <= ram_dout.
  - If ram_tx_valid = 0, set rd_err.
  - → RD_DONE.
- RD_DONE: ack[id] = 1; rdata valid → IDLE.
- Latency from grant cycle (the IDLE cycle that sees req) to ack cycle: write 2, read 4. Ack cycle to next grant: at least 1 cycle, because IDLE is always revisited.
- ram_tx_valid is only sampled in RD_WAIT. The RAM leaves tx_valid high after reads, so it is never used as an event.
- Requester contract: req deasserts on the edge ending the ack cycle. A req still high in IDLE is treated as a new request.
- Simultaneous events:
  - A req arriving during an active sequence waits in IDLE arbitration; no preemption.
  - A continuously requesting pair alternates grants strictly.

Optional Feature:
- Macro: RAM_ARBITER_ADDR_CACHE_EN.
- Defined:
  - The arbiter keeps shadow copies of the RAM's write and read address registers (wr_sh/wr_v, rd_sh/rd_v), cleared to invalid on reset.
  - The shadow is updated when a WR_ADDR or RD_ADDR beat issues.
  - A write hit (wr_v and addr == wr_sh) goes IDLE → WR_DATA directly; write latency 1.
  - A read hit goes IDLE → RD_CMD directly; read latency 3.
- Undefined: the full sequence is always issued and no shadow registers exist.

Test Plan:
- Reset, then req[0]=1, we=1, addr=0x12, wdata=0xA5:
  - ram_din = 0x012 with rx_valid in cycle +1;
  - ram_din = 0x1A5 in cycle +2 with ack[0] = 1;
  - then rx_valid = 0.
- Read from req[1], addr=0x12 after the above:
  - ram_din = 0x212, then 0x300;
  - ack[1] in cycle +4 with rdata = 0xA5;
  - rd_err = 0.
- Both req high from reset (both reads, addrs 0x01/0x02):
  - requester 0 is granted first, then requester 1;
  - no interleaving of ram_din beats;
  - with both held continuously, grants alternate 0,1,0,1.
- Assert rst_n low during RD_CMD:
  - all outputs return to reset values immediately;
  - after release, the reissued read completes normally.
- Read with a model RAM forcing ram_tx_valid = 0 in RD_WAIT: rd_err = 1 and stays 1 until reset.
- With RAM_ARBITER_ADDR_CACHE_EN defined, two writes to 0x40 (data 0x11, then 0x22):
  - the second write issues only the 0x122 beat, with ack 1 cycle after grant;
  - a subsequent read of 0x40 returns 0x22.
